keycode_scheduler: RTL and testbench

KEYCODE_SCHEDULER -- requirements
Module: keycode_scheduler

---
 rtl/keycode_scheduler.sv | 154 +++++++++++++++
 tb/tb_keycode_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_scheduler.sv
// rtl/keycode_scheduler.sv - Avalon-MM keycode FIFO replayed to game logic, one key per HOLD frame ticks
// Keys are queued by the CPU and presented on out_port, each held for a programmable number of frames.
module keycode_scheduler #(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] HOLD_RST = 8'd1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        frame_tick,
   output logic [7:0]  out_port,
   output logic        key_valid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t          state, state_nxt;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [FW-1:0]   fill;
   logic            overflow;
   logic [7:0]      hold_reg;
   logic [7:0]      cnt;

   logic wr, push, hold_we, stat_we, flush, ov_clr;
   logic full, pop, push_ok;
   logic load_key, clr_key, dec_cnt;

   assign wr      = chipselect & ~write_n;
   assign push    = wr && (address == 2'd0);
   assign hold_we = wr && (address == 2'd1);
   assign stat_we = wr && (address == 2'd2);
   assign flush   = stat_we & writedata[0];
   assign ov_clr  = stat_we & writedata[8];

   assign full    = (fill == FILL_MAX);
   assign pop     = (state == LOAD) && (fill != '0);
   // A flush discards a coincident push; a full FIFO only accepts when the head leaves this cycle.
   assign push_ok = push && !flush && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         overflow <= 1'b0;
         hold_reg <= HOLD_RST;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
               2'b10:   fill <= fill + 1'b1;
               2'b01:   fill <= fill - 1'b1;
               default: fill <= fill;
            endcase
         end
         if (push && !flush && full && !pop)
            overflow <= 1'b1;
         else if (ov_clr)
            overflow <= 1'b0;
         if (hold_we)
            hold_reg <= (writedata[7:0] == 8'd0) ? 8'd1 : writedata[7:0];
      end
   end

   always_comb begin
      state_nxt = state;
      load_key  = 1'b0;
      clr_key   = 1'b0;
      dec_cnt   = 1'b0;
      case (state)
         IDLE: begin
            if (fill != '0)
               state_nxt = LOAD;
         end
         LOAD: begin
            // The queue can be flushed between IDLE and LOAD, leaving nothing to pop.
            if (fill != '0) begin
               state_nxt = HOLD;
               load_key  = 1'b1;
            end else begin
               state_nxt = IDLE;
               clr_key   = 1'b1;
            end
         end
         HOLD: begin
            if (frame_tick) begin
               if (cnt <= 8'd1) begin
                  if (fill != '0 && !flush) begin
                     state_nxt = LOAD;
                  end else begin
                     state_nxt = IDLE;
                     clr_key   = 1'b1;
                  end
               end else begin
                  dec_cnt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         out_port <= 8'd0;
         cnt      <= 8'd0;
      end else begin
         state <= state_nxt;
         if (load_key) begin
            out_port <= mem[rd_ptr];
            cnt      <= hold_reg;
         end else if (clr_key) begin
            out_port <= 8'd0;
         end else if (dec_cnt) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign key_valid = (state == HOLD);

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata = {24'd0, out_port};
         2'd1:    readdata = {24'd0, hold_reg};
         2'd2:    readdata = {22'd0, (state != IDLE), overflow, 3'd0, 5'(fill)};
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_keycode_scheduler.sv
// tb/tb_keycode_scheduler.sv - self-checking bench for keycode_scheduler
module tb_keycode_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        frame_tick = 1'b0;
   logic [7:0]  out_port;
   logic        key_valid;

   keycode_scheduler #(.DEPTH(4), .HOLD_RST(8'd1)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .frame_tick(frame_tick), .out_port(out_port), .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   int         vec = 0;
   int         err = 0;
   logic [7:0] exp_q [$];
   logic [7:0] sb_e;
   logic       kv_prev = 1'b0;
   logic [31:0] rv;

   typedef struct {
      bit          we;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [1:0]  ra;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Caller is positioned between edges; the strobe spans exactly one rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic push_key(input logic [7:0] k, input bit accepted);
      if (accepted) exp_q.push_back(k);
      wr(2'd0, {24'd0, k});
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      v = readdata;
      chipselect = 1'b0;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic wait_kv();
      int n;
      n = 0;
      while (!key_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_kv", {31'd0, key_valid}, 32'd1);
   endtask

   // Scoreboard: every new keycode presentation must match the next queued key.
   always @(negedge clk) begin
      if (key_valid && !kv_prev) begin
         if (exp_q.size() == 0) begin
            vec++;
            err++;
            $display("FAIL sb_unexpected: got %h expected no key", out_port);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_key", {24'd0, out_port}, {24'd0, sb_e});
         end
      end
      kv_prev = key_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 2'd0, 32'h0,         2'd0, 32'h0};
      tbl[1] = '{0, 2'd0, 32'h0,         2'd1, 32'h1};
      tbl[2] = '{0, 2'd0, 32'h0,         2'd2, 32'h0};
      tbl[3] = '{0, 2'd0, 32'h0,         2'd3, 32'h0};
      tbl[4] = '{1, 2'd1, 32'h5,         2'd1, 32'h5};
      tbl[5] = '{1, 2'd1, 32'h0,         2'd1, 32'h1};
      tbl[6] = '{1, 2'd1, 32'hFFFF_FF80, 2'd1, 32'h80};
      tbl[7] = '{1, 2'd3, 32'hFFFF_FFFF, 2'd1, 32'h80};
      tbl[8] = '{1, 2'd2, 32'h101,       2'd2, 32'h0};
      tbl[9] = '{1, 2'd1, 32'h1,         2'd3, 32'h0};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("rst_kv", {31'd0, key_valid}, 32'd0);
      chk("rst_out", {24'd0, out_port}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) wr(tbl[i].wa, tbl[i].wd);
         rd(tbl[i].ra, rv);
         chk($sformatf("tbl%0d", i), rv, tbl[i].exp);
      end
      rd(2'd1, rv);
      chk("hold_restored", rv, 32'h1);
      @(negedge clk);

      // Single key, HOLD=1: visible two cycles after the write edge, gone after one tick.
      push_key(8'h1A, 1);
      chk("lat_kv0", {31'd0, key_valid}, 32'd0);
      rd(2'd2, rv);
      chk("lat_stat0", rv, 32'h001);
      @(negedge clk);
      chk("lat_kv1", {31'd0, key_valid}, 32'd0);
      rd(2'd2, rv);
      chk("lat_stat1", rv, 32'h201);
      @(negedge clk);
      chk("lat_kv2", {31'd0, key_valid}, 32'd1);
      chk("lat_out2", {24'd0, out_port}, 32'h1A);
      tick();
      chk("h1_kv", {31'd0, key_valid}, 32'd0);
      chk("h1_out", {24'd0, out_port}, 32'h0);

      // HOLD=3 with two keys.
      wr(2'd1, 32'd3);
      push_key(8'h04, 1);
      push_key(8'h07, 1);
      wait_kv();
      tick(); tick();
      chk("h3_out", {24'd0, out_port}, 32'h04);
      chk("h3_kv", {31'd0, key_valid}, 32'd1);
      tick();
      chk("h3_load_kv", {31'd0, key_valid}, 32'd0);
      @(negedge clk);
      chk("h3_next_out", {24'd0, out_port}, 32'h07);
      tick(); tick(); tick();
      chk("h3_idle_kv", {31'd0, key_valid}, 32'd0);
      rd(2'd2, rv);
      chk("h3_idle_stat", rv, 32'h0);
      @(negedge clk);

      // Overflow with HOLD=255, then a push coinciding with the LOAD pop on a full FIFO.
      wr(2'd1, 32'd255);
      for (int k = 0; k < 6; k++) push_key(8'h11 + 8'(k), k < 5);
      rd(2'd2, rv);
      chk("ovf_stat", rv, 32'h304);
      chk("ovf_out", {24'd0, out_port}, 32'h11);
      wr(2'd2, 32'h100);
      rd(2'd2, rv);
      chk("ovf_clr", rv, 32'h204);
      wr(2'd1, 32'd1);
      for (int k = 0; k < 254; k++) tick();
      chk("h255_out", {24'd0, out_port}, 32'h11);
      chk("h255_kv", {31'd0, key_valid}, 32'd1);
      tick();
      push_key(8'h17, 1);
      rd(2'd2, rv);
      chk("full_pushpop_stat", rv, 32'h204);
      repeat (5) begin
         wait_kv();
         tick();
      end
      rd(2'd2, rv);
      chk("drain_stat", rv, 32'h0);
      @(negedge clk);

      // Flush during HOLD leaves the held key alone.
      wr(2'd1, 32'd2);
      push_key(8'h2C, 1);
      push_key(8'h2D, 1);
      push_key(8'h2E, 1);
      wait_kv();
      rd(2'd2, rv);
      chk("fl_pre", rv, 32'h202);
      wr(2'd2, 32'h1);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      rd(2'd2, rv);
      chk("fl_stat", rv, 32'h200);
      chk("fl_out", {24'd0, out_port}, 32'h2C);
      tick(); tick();
      chk("fl_idle_kv", {31'd0, key_valid}, 32'd0);
      rd(2'd2, rv);
      chk("fl_idle_stat", rv, 32'h0);
      @(negedge clk);

      // Asynchronous reset mid-HOLD.
      wr(2'd1, 32'd5);
      push_key(8'h3A, 1);
      push_key(8'h3B, 1);
      wait_kv();
      #2 reset_n = 1'b0;
      #1;
      chk("ar_out", {24'd0, out_port}, 32'h0);
      chk("ar_kv", {31'd0, key_valid}, 32'd0);
      rd(2'd2, rv);
      chk("ar_stat", rv, 32'h0);
      rd(2'd1, rv);
      chk("ar_hold", rv, 32'h1);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd(2'd2, rv);
      chk("ar_post_stat", rv, 32'h0);
      push_key(8'h55, 1);
      wait_kv();
      tick();
      chk("ar_post_kv", {31'd0, key_valid}, 32'd0);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
